spi_slave_3wire: RTL and testbench

- 3-wire SPI target (shared bidirectional data line, chip-select, clock) in the wb_clk_i domain; the counterpart of the 3-wire SPI master used in this codebase.
- Oversamples sck/cs_n/sdio, decodes a command byte, then writes or reads an 8-bit register file through a simple one-cycle register port.
- Used on test boards and in loopback benches as the far end of the bidirectional SPI link.

---
 rtl/spi_slave_3wire.sv | 160 ++++++++++++++++
 tb/tb_spi_slave_3wire.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_3wire.sv
// rtl/spi_slave_3wire.sv - 3-wire SPI target (mode 0) driving an 8-bit register port
// Optional burst address auto-increment: define SPI_SLAVE_ADDR_AUTOINC_EN.
module spi_slave_3wire #(
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              sck_i,
    input  logic              cs_n_i,
    input  logic              sdio_i,
    output logic              sdio_o,
    output logic              sdio_oe_o,
    output logic [ADDR_W-1:0] reg_addr_o,
    output logic [DATA_W-1:0] reg_wdata_o,
    output logic              reg_we_o,
    output logic              reg_re_o,
    input  logic [DATA_W-1:0] reg_rdata_i,
    output logic              busy_o
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CMD   = 3'd1;
    localparam logic [2:0] ST_WDATA = 3'd2;
    localparam logic [2:0] ST_RLOAD = 3'd3;
    localparam logic [2:0] ST_RDATA = 3'd4;

    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] sdio_sync;
    logic                   sck_prev;
    logic                   cs_prev;
    logic [2:0]             state;
    logic [2:0]             bit_cnt;
    logic [DATA_W-1:0]      rx_shift;
    logic [DATA_W-1:0]      tx_shift;

    logic              sck_s;
    logic              cs_s;
    logic              sdio_s;
    logic              sck_rise;
    logic              sck_fall;
    logic              cs_rise;
    logic              cs_fall;
    logic [DATA_W-1:0] rx_next;

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign sdio_s   = sdio_sync[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev;
    assign sck_fall = ~sck_s & sck_prev;
    assign cs_rise  = cs_s & ~cs_prev;
    assign cs_fall  = ~cs_s & cs_prev;
    assign rx_next  = {rx_shift[DATA_W-2:0], sdio_s};

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            sck_sync    <= '0;
            cs_sync     <= '1;
            sdio_sync   <= '0;
            sck_prev    <= 1'b0;
            cs_prev     <= 1'b1;
            state       <= ST_IDLE;
            bit_cnt     <= 3'd0;
            rx_shift    <= '0;
            tx_shift    <= '0;
            sdio_o      <= 1'b0;
            sdio_oe_o   <= 1'b0;
            reg_addr_o  <= '0;
            reg_wdata_o <= '0;
            reg_we_o    <= 1'b0;
            reg_re_o    <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck_i};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n_i};
            sdio_sync <= {sdio_sync[SYNC_STAGES-2:0], sdio_i};
            sck_prev  <= sck_s;
            cs_prev   <= cs_s;
            busy_o    <= ~cs_s;
            reg_we_o  <= 1'b0;
            reg_re_o  <= 1'b0;

`ifdef SPI_SLAVE_ADDR_AUTOINC_EN
            // Advance after the write strobe so the strobe sees the old address.
            if (reg_we_o) begin
                reg_addr_o <= reg_addr_o + ADDR_W'(1);
            end
`endif

            // Deselect beats any sck edge in the same cycle; partial bytes are dropped.
            if (cs_rise) begin
                state     <= ST_IDLE;
                sdio_oe_o <= 1'b0;
                bit_cnt   <= 3'd0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (cs_fall) begin
                            state    <= ST_CMD;
                            bit_cnt  <= 3'd0;
                            rx_shift <= '0;
                        end
                    end
                    ST_CMD: begin
                        if (sck_rise) begin
                            rx_shift <= rx_next;
                            bit_cnt  <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                reg_addr_o <= rx_next[ADDR_W-1:0];
                                if (rx_next[DATA_W-1]) begin
                                    reg_re_o <= 1'b1;
                                    state    <= ST_RLOAD;
                                end else begin
                                    state <= ST_WDATA;
                                end
                            end
                        end
                    end
                    ST_WDATA: begin
                        if (sck_rise) begin
                            rx_shift <= rx_next;
                            bit_cnt  <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                reg_wdata_o <= rx_next;
                                reg_we_o    <= 1'b1;
                            end
                        end
                    end
                    ST_RLOAD: begin
                        // Read data is valid the cycle after the strobe drops.
                        if (!reg_re_o) begin
                            tx_shift <= reg_rdata_i;
                            state    <= ST_RDATA;
                        end
                    end
                    ST_RDATA: begin
                        if (sck_fall) begin
                            sdio_oe_o <= 1'b1;
                            sdio_o    <= tx_shift[DATA_W-1];
                            tx_shift  <= {tx_shift[DATA_W-2:0], 1'b0};
                        end else if (sck_rise) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
`ifdef SPI_SLAVE_ADDR_AUTOINC_EN
                                reg_addr_o <= reg_addr_o + ADDR_W'(1);
`endif
                                reg_re_o <= 1'b1;
                                state    <= ST_RLOAD;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_3wire.sv
// tb/tb_spi_slave_3wire.sv - directed self-checking bench for spi_slave_3wire
module tb_spi_slave_3wire;

    logic       clk = 1'b0;
    logic       wb_rst_i;
    logic       sck;
    logic       cs_n;
    logic       sdio_m;
    logic       sdio_o;
    logic       sdio_oe_o;
    logic [6:0] reg_addr_o;
    logic [7:0] reg_wdata_o;
    logic       reg_we_o;
    logic       reg_re_o;
    logic [7:0] reg_rdata;
    logic       busy_o;
    logic       init_mem;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] mem [128];
    logic [6:0] wr_addr_log [64];
    logic [7:0] wr_data_log [64];
    logic [6:0] re_addr_log [64];
    int         wr_total  = 0;
    int         re_total  = 0;
    int         oe_cycles = 0;

    always #5 clk = ~clk;

    spi_slave_3wire dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (wb_rst_i),
        .sck_i       (sck),
        .cs_n_i      (cs_n),
        .sdio_i      (sdio_m),
        .sdio_o      (sdio_o),
        .sdio_oe_o   (sdio_oe_o),
        .reg_addr_o  (reg_addr_o),
        .reg_wdata_o (reg_wdata_o),
        .reg_we_o    (reg_we_o),
        .reg_re_o    (reg_re_o),
        .reg_rdata_i (reg_rdata),
        .busy_o      (busy_o)
    );

    // Register-file model on the far side of the register port.
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 128; i++) mem[i] <= 8'h00;
            mem[3]    <= 8'h3C;
            mem[4]    <= 8'hC4;
            reg_rdata <= 8'h00;
        end else begin
            if (reg_we_o) begin
                mem[reg_addr_o]           <= reg_wdata_o;
                wr_addr_log[wr_total % 64] <= reg_addr_o;
                wr_data_log[wr_total % 64] <= reg_wdata_o;
                wr_total                  <= wr_total + 1;
            end
            if (reg_re_o) begin
                reg_rdata                 <= mem[reg_addr_o];
                re_addr_log[re_total % 64] <= reg_addr_o;
                re_total                  <= re_total + 1;
            end
            if (sdio_oe_o) oe_cycles <= oe_cycles + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic half();
        repeat (5) @(negedge clk);
    endtask

    task automatic cs_begin();
        cs_n = 1'b0;
        half();
        half();
    endtask

    task automatic cs_end();
        half();
        cs_n = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic send_bits(input logic [7:0] b, input int nbits);
        for (int i = 7; i > 7 - nbits; i--) begin
            sdio_m = b[i];
            half();
            sck = 1'b1;
            half();
            sck = 1'b0;
        end
    endtask

    task automatic recv_bits(output logic [7:0] b, input int nbits);
        b = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            half();
            b[i] = sdio_o;
            sck = 1'b1;
            half();
            sck = 1'b0;
        end
    endtask

    int         wb;
    int         rb;
    int         oe0;
    int         k;
    logic [7:0] rd;
    logic [7:0] rd2;
    logic [6:0] exp_burst [3];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        wb_rst_i = 1'b1;
        init_mem = 1'b1;
        cs_n     = 1'b1;
        sck      = 1'b0;
        sdio_m   = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_oe", sdio_oe_o, 0);
        check("rst_sdo", sdio_o, 0);
        check("rst_we", reg_we_o, 0);
        check("rst_re", reg_re_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_addr", reg_addr_o, 0);
        check("rst_wdata", reg_wdata_o, 0);
        wb_rst_i = 1'b0;
        init_mem = 1'b0;
        repeat (5) @(negedge clk);

        // Single write
        wb = wr_total; oe0 = oe_cycles;
        cs_begin();
        check("busy_active", busy_o, 1);
        send_bits(8'h05, 8);
        send_bits(8'hA5, 8);
        cs_end();
        check("wr_cnt", wr_total - wb, 1);
        check("wr_addr", wr_addr_log[wb % 64], 7'h05);
        check("wr_data", wr_data_log[wb % 64], 8'hA5);
        check("wr_oe_quiet", oe_cycles - oe0, 0);

        // Single read, then watch the pad release after deselect
        rb = re_total;
        cs_begin();
        send_bits(8'h83, 8);
        recv_bits(rd, 8);
        half();
        check("rd_oe_active", sdio_oe_o, 1);
        cs_n = 1'b1;
        for (k = 0; k < 20 && busy_o; k++) @(negedge clk);
        check("rd_busy_fall", busy_o, 0);
        check("rd_oe_release", sdio_oe_o, 0);
        repeat (20) @(negedge clk);
        check("rd_data", rd, 8'h3C);
        check("rd_addr", re_addr_log[rb % 64], 7'h03);
        check("rd_re_cnt_incl_prefetch", re_total - rb, 2);

        // Burst write across the top of the address space
`ifdef SPI_SLAVE_ADDR_AUTOINC_EN
        exp_burst[0] = 7'h7E; exp_burst[1] = 7'h7F; exp_burst[2] = 7'h00;
`else
        exp_burst[0] = 7'h7E; exp_burst[1] = 7'h7E; exp_burst[2] = 7'h7E;
`endif
        wb = wr_total;
        cs_begin();
        send_bits(8'h7E, 8);
        send_bits(8'h11, 8);
        send_bits(8'h22, 8);
        send_bits(8'h33, 8);
        cs_end();
        check("bw_cnt", wr_total - wb, 3);
        check("bw_addr0", wr_addr_log[wb % 64], exp_burst[0]);
        check("bw_addr1", wr_addr_log[(wb + 1) % 64], exp_burst[1]);
        check("bw_addr2", wr_addr_log[(wb + 2) % 64], exp_burst[2]);
        check("bw_data0", wr_data_log[wb % 64], 8'h11);
        check("bw_data1", wr_data_log[(wb + 1) % 64], 8'h22);
        check("bw_data2", wr_data_log[(wb + 2) % 64], 8'h33);

        // Two-byte burst read from address 3
        cs_begin();
        send_bits(8'h83, 8);
        recv_bits(rd, 8);
        recv_bits(rd2, 8);
        cs_end();
        check("br_data0", rd, 8'h3C);
`ifdef SPI_SLAVE_ADDR_AUTOINC_EN
        check("br_data1", rd2, 8'hC4);
`else
        check("br_data1", rd2, 8'h3C);
`endif

        // Abort after 5 data bits, then a clean write to the same address
        wb = wr_total;
        cs_begin();
        send_bits(8'h10, 8);
        send_bits(8'hFF, 5);
        cs_end();
        check("abort_no_we", wr_total - wb, 0);
        check("abort_busy", busy_o, 0);
        check("abort_oe", sdio_oe_o, 0);
        cs_begin();
        send_bits(8'h10, 8);
        send_bits(8'h99, 8);
        cs_end();
        check("post_abort_cnt", wr_total - wb, 1);
        check("post_abort_addr", wr_addr_log[wb % 64], 7'h10);
        check("post_abort_data", wr_data_log[wb % 64], 8'h99);

        // Reset in the middle of a read byte
        cs_begin();
        send_bits(8'h83, 8);
        recv_bits(rd, 3);
        wb_rst_i = 1'b1;
        cs_n     = 1'b1;
        @(negedge clk);
        check("mrst_oe", sdio_oe_o, 0);
        check("mrst_sdo", sdio_o, 0);
        check("mrst_re", reg_re_o, 0);
        check("mrst_we", reg_we_o, 0);
        check("mrst_busy", busy_o, 0);
        check("mrst_addr", reg_addr_o, 0);
        repeat (3) @(negedge clk);
        wb_rst_i = 1'b0;
        repeat (10) @(negedge clk);

        // Back-to-back write then read of the same register
        wb = wr_total;
        cs_begin();
        send_bits(8'h20, 8);
        send_bits(8'h5A, 8);
        cs_end();
        cs_begin();
        send_bits(8'hA0, 8);
        recv_bits(rd, 8);
        cs_end();
        check("b2b_wr_addr", wr_addr_log[wb % 64], 7'h20);
        check("b2b_rd_data", rd, 8'h5A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
